// File: rtl/issue_pair_buffer_if.sv
// issue_pair_buffer_if: fetch/issue-side signal bundle for issue_pair_buffer. Rev 1.0
// Optional: ISSUE_PAIR_STATS_EN adds the stat_* counter outputs.
`default_nettype none

interface issue_pair_buffer_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_instr1;
  logic [31:0]   in_instr2;
  logic [31:0]   in_pc;
  logic          stall;
  logic          stall_outer_dependent;
  logic          flush;
  logic [1:0]    swap1;
  logic [1:0]    swap2;
  logic [31:0]   out_instr1;
  logic [31:0]   out_instr2;
  logic [31:0]   out_pc1;
  logic [31:0]   out_pc2;
  logic          out_valid;
  logic [CW-1:0] count;
`ifdef ISSUE_PAIR_STATS_EN
  logic [31:0]   stat_pairs;
  logic [31:0]   stat_partial;
  logic [31:0]   stat_hold_cycles;

  modport slave (
    input  in_valid, in_instr1, in_instr2, in_pc,
    input  stall, stall_outer_dependent, flush, swap1, swap2,
    output in_ready, out_instr1, out_instr2, out_pc1, out_pc2, out_valid, count,
    output stat_pairs, stat_partial, stat_hold_cycles
  );

  modport master (
    output in_valid, in_instr1, in_instr2, in_pc,
    output stall, stall_outer_dependent, flush, swap1, swap2,
    input  in_ready, out_instr1, out_instr2, out_pc1, out_pc2, out_valid, count,
    input  stat_pairs, stat_partial, stat_hold_cycles
  );
`else
  modport slave (
    input  in_valid, in_instr1, in_instr2, in_pc,
    input  stall, stall_outer_dependent, flush, swap1, swap2,
    output in_ready, out_instr1, out_instr2, out_pc1, out_pc2, out_valid, count
  );

  modport master (
    output in_valid, in_instr1, in_instr2, in_pc,
    output stall, stall_outer_dependent, flush, swap1, swap2,
    input  in_ready, out_instr1, out_instr2, out_pc1, out_pc2, out_valid, count
  );
`endif

endinterface

`default_nettype wire

// File: rtl/issue_pair_buffer.sv
// issue_pair_buffer: FIFO of fetched instruction pairs feeding the D-stage pair register. Rev 1.0
// Optional: ISSUE_PAIR_STATS_EN adds saturating stat_pairs/stat_partial/stat_hold_cycles counters.
`default_nettype none

module issue_pair_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] NOP_WORD = 32'h2000_0000
) (
  input  wire logic          clk,
  input  wire logic          rst,
  issue_pair_buffer_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] instr1;
    logic [31:0] instr2;
    logic [31:0] pc;
  } pair_t;

  pair_t          mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  occ;
  logic [31:0]    instr1_q;
  logic [31:0]    instr2_q;
  logic [31:0]    pc1_q;
  logic           valid_q;

  logic           empty;
  logic           push;
  logic           pop;
  logic           partial;
  logic           slot1_issued;
  logic           slot2_issued;
  logic           adv;
  pair_t          head;
  pair_t          in_pair;

  assign empty        = (occ == '0);
  // Full check deliberately ignores a same-cycle pop.
  assign bus.in_ready = (occ < CW'(DEPTH));
  assign push         = bus.in_valid & bus.in_ready & ~bus.flush;

  assign partial      = bus.stall & ~bus.stall_outer_dependent & valid_q;
  assign slot1_issued = (bus.swap1 == 2'b00) | (bus.swap2 == 2'b01);
  assign slot2_issued = (bus.swap2 == 2'b00) | (bus.swap1 == 2'b01);
  // Both slots leaving in a partial-issue cycle frees D exactly like a normal advance.
  assign adv          = (~bus.stall | ~valid_q | (partial & slot1_issued & slot2_issued)) & ~bus.flush;
  assign pop          = adv & ~empty;

  assign head    = mem[rd_ptr];
  assign in_pair = '{instr1: bus.in_instr1, instr2: bus.in_instr2, pc: bus.in_pc};

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_pair;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      occ <= occ + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr1_q <= NOP_WORD;
      instr2_q <= NOP_WORD;
      pc1_q    <= '0;
      valid_q  <= 1'b0;
    end else if (bus.flush) begin
      instr1_q <= NOP_WORD;
      instr2_q <= NOP_WORD;
      valid_q  <= 1'b0;
    end else if (adv) begin
      if (!empty) begin
        instr1_q <= head.instr1;
        instr2_q <= head.instr2;
        pc1_q    <= head.pc;
        valid_q  <= 1'b1;
      end else begin
        instr1_q <= NOP_WORD;
        instr2_q <= NOP_WORD;
        valid_q  <= 1'b0;
      end
    end else if (partial) begin
      if (slot1_issued) instr1_q <= NOP_WORD;
      if (slot2_issued) instr2_q <= NOP_WORD;
    end
  end

  assign bus.out_instr1 = instr1_q;
  assign bus.out_instr2 = instr2_q;
  assign bus.out_pc1    = pc1_q;
  assign bus.out_pc2    = pc1_q + 32'd4;
  assign bus.out_valid  = valid_q;
  assign bus.count      = occ;

`ifdef ISSUE_PAIR_STATS_EN
  logic [31:0] stat_pairs_q;
  logic [31:0] stat_partial_q;
  logic [31:0] stat_hold_q;

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_pairs_q   <= '0;
      stat_partial_q <= '0;
      stat_hold_q    <= '0;
    end else begin
      if (pop && stat_pairs_q != '1)
        stat_pairs_q <= stat_pairs_q + 32'd1;
      if (partial && !bus.flush && (slot1_issued || slot2_issued) && stat_partial_q != '1)
        stat_partial_q <= stat_partial_q + 32'd1;
      if (valid_q && bus.stall && stat_hold_q != '1)
        stat_hold_q <= stat_hold_q + 32'd1;
    end
  end

  assign bus.stat_pairs       = stat_pairs_q;
  assign bus.stat_partial     = stat_partial_q;
  assign bus.stat_hold_cycles = stat_hold_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_issue_pair_buffer.sv
// tb_issue_pair_buffer: directed self-checking bench for issue_pair_buffer. Rev 1.0
`default_nettype none

module tb_issue_pair_buffer;

  localparam logic [31:0] NOP = 32'h2000_0000;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  issue_pair_buffer_if #(.DEPTH(4)) bus ();

  issue_pair_buffer #(.DEPTH(4), .NOP_WORD(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] i1, input logic [31:0] i2, input logic [31:0] pc);
    bus.in_valid  = v;
    bus.in_instr1 = i1;
    bus.in_instr2 = i2;
    bus.in_pc     = pc;
  endtask

  task automatic ctl(input logic st, input logic sod, input logic [1:0] s1, input logic [1:0] s2);
    bus.stall                 = st;
    bus.stall_outer_dependent = sod;
    bus.swap1                 = s1;
    bus.swap2                 = s2;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b0;
    bus.flush = 1'b0;
    drive(1'b0, '0, '0, '0);
    ctl(1'b0, 1'b0, 2'b00, 2'b00);
    step();
    step();

    chk("rst_count",  32'(bus.count), 32'd0);
    chk("rst_valid",  32'(bus.out_valid), 32'd0);
    chk("rst_instr1", bus.out_instr1, NOP);
    chk("rst_instr2", bus.out_instr2, NOP);
    chk("rst_pc1",    bus.out_pc1, 32'h0);
    chk("rst_pc2",    bus.out_pc2, 32'h4);
    chk("rst_ready",  32'(bus.in_ready), 32'd1);
    rst = 1'b1;

    // First pair: no bypass, so D fills one edge after the push.
    drive(1'b1, 32'h012A4020, 32'h01495022, 32'h100);
    step();
    chk("t1_count_e1", 32'(bus.count), 32'd1);
    chk("t1_valid_e1", 32'(bus.out_valid), 32'd0);
    drive(1'b0, '0, '0, '0);
    step();
    chk("t1_valid",  32'(bus.out_valid), 32'd1);
    chk("t1_instr1", bus.out_instr1, 32'h012A4020);
    chk("t1_instr2", bus.out_instr2, 32'h01495022);
    chk("t1_pc1",    bus.out_pc1, 32'h100);
    chk("t1_pc2",    bus.out_pc2, 32'h104);
    chk("t1_count",  32'(bus.count), 32'd0);

    // Fill to full under a full hold, try a fifth push, then drain in order.
    ctl(1'b1, 1'b1, 2'b00, 2'b00);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h1111_0000 + 32'(i), 32'h2222_0000 + 32'(i), 32'h200 + 32'(8 * i));
      step();
    end
    chk("t2_count_full", 32'(bus.count), 32'd4);
    chk("t2_ready_full", 32'(bus.in_ready), 32'd0);
    chk("t2_hold_instr", bus.out_instr1, 32'h012A4020);
    drive(1'b1, 32'hDEAD_0001, 32'hDEAD_0002, 32'h900);
    step();
    chk("t2_count_5th", 32'(bus.count), 32'd4);
    chk("t2_hold_pc",   bus.out_pc1, 32'h100);
    drive(1'b0, '0, '0, '0);
    ctl(1'b0, 1'b0, 2'b00, 2'b00);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t2_drain_i1",  bus.out_instr1, 32'h1111_0000 + 32'(i));
      chk("t2_drain_i2",  bus.out_instr2, 32'h2222_0000 + 32'(i));
      chk("t2_drain_pc",  bus.out_pc1, 32'h200 + 32'(8 * i));
      chk("t2_drain_cnt", 32'(bus.count), 32'(3 - i));
    end
    step();
    chk("t2_empty_valid", 32'(bus.out_valid), 32'd0);
    chk("t2_empty_i1",    bus.out_instr1, NOP);
    chk("t2_empty_i2",    bus.out_instr2, NOP);

    // Partial issue.
    drive(1'b1, 32'hAAAA_0001, 32'hAAAA_0002, 32'h300);
    step();
    chk("t3_count_b", 32'(bus.count), 32'd1);
    drive(1'b1, 32'hBBBB_0001, 32'hBBBB_0002, 32'h400);
    step();
    chk("t3_load_b",  bus.out_instr1, 32'hAAAA_0001);
    chk("t3_count_c", 32'(bus.count), 32'd1);
    drive(1'b0, '0, '0, '0);
    ctl(1'b1, 1'b0, 2'b10, 2'b01);
    step();
    chk("t3_p1_i1",    bus.out_instr1, NOP);
    chk("t3_p1_i2",    bus.out_instr2, 32'hAAAA_0002);
    chk("t3_p1_valid", 32'(bus.out_valid), 32'd1);
    chk("t3_p1_pc",    bus.out_pc1, 32'h300);
    chk("t3_p1_count", 32'(bus.count), 32'd1);
    ctl(1'b0, 1'b0, 2'b00, 2'b00);
    step();
    chk("t3_next_i1", bus.out_instr1, 32'hBBBB_0001);
    chk("t3_next_pc", bus.out_pc1, 32'h400);
    chk("t3_next_cnt", 32'(bus.count), 32'd0);
    ctl(1'b1, 1'b0, 2'b01, 2'b10);
    step();
    chk("t3_p2_i1",    bus.out_instr1, 32'hBBBB_0001);
    chk("t3_p2_i2",    bus.out_instr2, NOP);
    chk("t3_p2_valid", 32'(bus.out_valid), 32'd1);

    // Flush with three pairs queued and a push in the same cycle.
    ctl(1'b1, 1'b1, 2'b00, 2'b00);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hF000_0000 + 32'(i), 32'hF100_0000 + 32'(i), 32'h600 + 32'(8 * i));
      step();
    end
    chk("t5_count3",    32'(bus.count), 32'd3);
    chk("t5_hold_i1",   bus.out_instr1, 32'hBBBB_0001);
    bus.flush = 1'b1;
    drive(1'b1, 32'hF000_0003, 32'hF100_0003, 32'h618);
    step();
    chk("t5_fl_count", 32'(bus.count), 32'd0);
    chk("t5_fl_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_fl_i1",    bus.out_instr1, NOP);
    chk("t5_fl_i2",    bus.out_instr2, NOP);
    chk("t5_fl_ready", 32'(bus.in_ready), 32'd1);
    bus.flush = 1'b0;
    drive(1'b0, '0, '0, '0);
    ctl(1'b0, 1'b0, 2'b00, 2'b00);
    step();
    chk("t5_drop_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_drop_count", 32'(bus.count), 32'd0);

    // Asynchronous reset in the middle of a burst.
    ctl(1'b1, 1'b1, 2'b00, 2'b00);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h7000_0000 + 32'(i), 32'h7100_0000 + 32'(i), 32'h700 + 32'(8 * i));
      step();
    end
    chk("t6_count2",  32'(bus.count), 32'd2);
    chk("t6_valid_d", 32'(bus.out_valid), 32'd1);
    drive(1'b0, '0, '0, '0);
    rst = 1'b0;
    #1;
    chk("t6_async_count", 32'(bus.count), 32'd0);
    chk("t6_async_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_async_i1",    bus.out_instr1, NOP);
    step();
    rst = 1'b1;
    ctl(1'b0, 1'b0, 2'b00, 2'b00);
    drive(1'b1, 32'h3333_0001, 32'h3333_0002, 32'hFFFF_FFFC);
    step();
    chk("t6_rel_count", 32'(bus.count), 32'd1);
    chk("t6_rel_valid", 32'(bus.out_valid), 32'd0);
    drive(1'b0, '0, '0, '0);
    step();
    chk("t6_first_valid", 32'(bus.out_valid), 32'd1);
    chk("t6_first_i1",    bus.out_instr1, 32'h3333_0001);
    chk("t6_first_pc1",   bus.out_pc1, 32'hFFFF_FFFC);
    chk("t6_pc2_wrap",    bus.out_pc2, 32'h0000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
